// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: next-PC select encoding
// (also driven by the EX branch logic) and fetch FSM state encoding.
package fetch_unit_pkg;

    typedef logic [1:0] pc_next_sel_t;

    localparam pc_next_sel_t STEP_FORWARD                = 2'b00;
    localparam pc_next_sel_t JUMP_TO_LABEL               = 2'b01;
    localparam pc_next_sel_t JUMP_TO_CALCULATED_REGISTER = 2'b10;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_REQ   = 2'd0;
    localparam fetch_state_t ST_WAIT  = 2'd1;
    localparam fetch_state_t ST_DRAIN = 2'd2;
    localparam fetch_state_t ST_FAULT = 2'd3;

    // 2'b11 falls through as a plain step.
    function automatic logic is_redirect(input logic ex_valid, input pc_next_sel_t sel);
        return ex_valid && ((sel == JUMP_TO_LABEL) || (sel == JUMP_TO_CALCULATED_REGISTER));
    endfunction

    function automatic logic [31:0] redirect_target(input pc_next_sel_t sel,
                                                    input logic [31:0] target_addr,
                                                    input logic [31:0] jalr_addr);
        if (sel == JUMP_TO_LABEL)
            return target_addr;
        return jalr_addr & ~32'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_slot.sv
// Decode-facing output register: one instruction slot with valid/ready,
// flush (wins over everything) and load from the memory response.
module fetch_slot
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic [XLEN-1:0] load_instr,
    input  logic [XLEN-1:0] load_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid    <= 1'b1;
            id_instr    <= load_instr;
            id_pc       <= load_pc;
            id_pc_plus4 <= load_pc + XLEN'(4);
        end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem requests, decode slot
// handshake, redirect flush with response draining, misaligned-target fault.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_REQ   | request at pc may issue when the decode slot can take it
//   ST_WAIT  | request accepted, waiting for its response beat
//   ST_DRAIN | redirected while a response is owed; drop the next beat
//   ST_FAULT | misaligned target; stalled until an aligned redirect
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [1:0]      pc_next_sel,
    input  logic [XLEN-1:0] target_addr,
    input  logic [XLEN-1:0] jalr_addr,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            fault_q;
    logic [XLEN-1:0] fault_pc_q;
    logic            owed_in_fault;

    logic            redirect;
    logic [XLEN-1:0] new_pc;
    logic            rsp_still_owed;
    logic            slot_free;
    logic            req_accept;
    logic            slot_load;

    assign redirect = is_redirect(ex_valid, pc_next_sel);
    assign new_pc   = redirect_target(pc_next_sel, target_addr, jalr_addr);

    // True when a response will still arrive after this cycle.
    always_comb begin
        rsp_still_owed = 1'b0;
        if (!imem_rsp_valid) begin
            case (state)
                ST_WAIT, ST_DRAIN: rsp_still_owed = 1'b1;
                ST_FAULT:          rsp_still_owed = owed_in_fault;
                default:           rsp_still_owed = 1'b0;
            endcase
        end
    end

    assign slot_free = !id_valid || id_ready;

    // Gated by rst_n so the request line drops the instant reset asserts.
    assign imem_req_valid = rst_n && (state == ST_REQ) && !redirect && slot_free;
    assign imem_req_addr  = pc;
    assign req_accept     = imem_req_valid && imem_req_ready;
    assign slot_load      = (state == ST_WAIT) && imem_rsp_valid && !redirect;

    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_REQ;
            pc            <= RESET_PC;
            req_pc        <= '0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
            owed_in_fault <= 1'b0;
        end else if (redirect) begin
            pc <= new_pc;
            if (new_pc[1]) begin
                state         <= ST_FAULT;
                fault_q       <= 1'b1;
                fault_pc_q    <= new_pc;
                owed_in_fault <= rsp_still_owed;
            end else begin
                state         <= rsp_still_owed ? ST_DRAIN : ST_REQ;
                fault_q       <= 1'b0;
                owed_in_fault <= 1'b0;
            end
        end else begin
            case (state)
                ST_REQ: begin
                    if (req_accept) begin
                        req_pc <= pc;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        pc    <= req_pc + XLEN'(4);
                        state <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rsp_valid)
                        state <= ST_REQ;
                end
                ST_FAULT: begin
                    if (imem_rsp_valid)
                        owed_in_fault <= 1'b0;
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    fetch_slot #(
        .XLEN(XLEN)
    ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .load       (slot_load),
        .load_instr (imem_rsp_data),
        .load_pc    (req_pc),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_pc_plus4(id_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand sequences
// for fault-with-owed-response, PC wrap and asynchronous reset mid-fetch.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [1:0]  pc_next_sel;
    logic [31:0] target_addr;
    logic [31:0] jalr_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int n_pass;
    int n_total;
    int mem_lat;
    int mem_cnt;
    logic [31:0] mem_addr;

    fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .pc_next_sel   (pc_next_sel),
        .target_addr   (target_addr),
        .jalr_addr     (jalr_addr),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .fetch_fault   (fetch_fault),
        .fault_pc      (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns ~addr, one beat `mem_lat` cycles after acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cnt        <= 0;
            mem_addr       <= '0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (mem_cnt == 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= ~mem_addr;
                mem_cnt        <= 0;
            end else if (mem_cnt > 1) begin
                mem_cnt <= mem_cnt - 1;
            end
            if (imem_req_valid && imem_req_ready) begin
                if (mem_lat <= 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= ~imem_req_addr;
                end else begin
                    mem_cnt  <= mem_lat - 1;
                    mem_addr <= imem_req_addr;
                end
            end
        end
    end

    typedef struct {
        logic        exv;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic [31:0] jalr;
        logic        rdy;
        logic        rrdy;
        int          lat;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_idpc;
        logic        e_flt;
        logic [31:0] e_fpc;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(logic exv, logic [1:0] sel, logic [31:0] tgt, logic [31:0] jalr,
                                logic rdy, logic rrdy, int lat,
                                logic e_req, logic [31:0] e_addr, logic e_idv, logic [31:0] e_idpc,
                                logic e_flt, logic [31:0] e_fpc);
        vec_t r;
        r.exv = exv; r.sel = sel; r.tgt = tgt; r.jalr = jalr;
        r.rdy = rdy; r.rrdy = rrdy; r.lat = lat;
        r.e_req = e_req; r.e_addr = e_addr; r.e_idv = e_idv; r.e_idpc = e_idpc;
        r.e_flt = e_flt; r.e_fpc = e_fpc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic exv, input logic [1:0] sel, input logic [31:0] tgt,
                         input logic [31:0] jalr);
        ex_valid    = exv;
        pc_next_sel = sel;
        target_addr = tgt;
        jalr_addr   = jalr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        chk({tag, ".id_valid"},  {31'd0, id_valid},       32'd0);
        chk({tag, ".fault"},     {31'd0, fetch_fault},    32'd0);
        chk({tag, ".id_instr"},  id_instr,    32'd0);
        chk({tag, ".id_pc"},     id_pc,       32'd0);
        chk({tag, ".id_pc4"},    id_pc_plus4, 32'd0);
        chk({tag, ".fault_pc"},  fault_pc,    32'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        mem_lat = 1;
        rst_n   = 1'b0;
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        drive(1'b0, 2'b00, 32'd0, 32'd0);

        //            exv sel    tgt          jalr         rdy rrdy lat  req addr        idv idpc        flt fpc
        vecs[0]  = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   1, 32'h0,      0, 32'h0,   0, 32'h0);
        vecs[1]  = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   0, 32'h0,      0, 32'h0,   0, 32'h0);
        vecs[2]  = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   1, 32'h4,      1, 32'h0,   0, 32'h0);
        vecs[3]  = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   0, 32'h4,      0, 32'h0,   0, 32'h0);
        vecs[4]  = mk(0, 2'b00, 32'h0,      32'h0,      0, 1, 1,   0, 32'h8,      1, 32'h4,   0, 32'h0);
        vecs[5]  = mk(0, 2'b00, 32'h0,      32'h0,      0, 1, 1,   0, 32'h8,      1, 32'h4,   0, 32'h0);
        vecs[6]  = mk(0, 2'b00, 32'h0,      32'h0,      0, 1, 1,   0, 32'h8,      1, 32'h4,   0, 32'h0);
        vecs[7]  = mk(0, 2'b00, 32'h0,      32'h0,      0, 1, 1,   0, 32'h8,      1, 32'h4,   0, 32'h0);
        vecs[8]  = mk(0, 2'b00, 32'h0,      32'h0,      0, 1, 1,   0, 32'h8,      1, 32'h4,   0, 32'h0);
        vecs[9]  = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 3,   1, 32'h8,      1, 32'h4,   0, 32'h0);
        vecs[10] = mk(1, 2'b01, 32'h100,    32'h0,      1, 1, 3,   0, 32'h8,      0, 32'h0,   0, 32'h0);
        vecs[11] = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 3,   0, 32'h100,    0, 32'h0,   0, 32'h0);
        vecs[12] = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 3,   0, 32'h100,    0, 32'h0,   0, 32'h0);
        vecs[13] = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   1, 32'h100,    0, 32'h0,   0, 32'h0);
        vecs[14] = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   0, 32'h100,    0, 32'h0,   0, 32'h0);
        vecs[15] = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   1, 32'h104,    1, 32'h100, 0, 32'h0);
        vecs[16] = mk(1, 2'b10, 32'h0,      32'h201,    1, 1, 1,   0, 32'h104,    0, 32'h0,   0, 32'h0);
        vecs[17] = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   1, 32'h200,    0, 32'h0,   0, 32'h0);
        vecs[18] = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   0, 32'h200,    0, 32'h0,   0, 32'h0);
        vecs[19] = mk(1, 2'b01, 32'h180,    32'h0,      0, 1, 1,   0, 32'h204,    1, 32'h200, 0, 32'h0);
        vecs[20] = mk(0, 2'b00, 32'h0,      32'h0,      0, 0, 1,   1, 32'h180,    0, 32'h0,   0, 32'h0);
        vecs[21] = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   1, 32'h180,    0, 32'h0,   0, 32'h0);
        vecs[22] = mk(1, 2'b10, 32'h0,      32'h202,    1, 1, 1,   0, 32'h180,    0, 32'h0,   0, 32'h0);
        vecs[23] = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   0, 32'h202,    0, 32'h0,   1, 32'h202);
        vecs[24] = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   0, 32'h202,    0, 32'h0,   1, 32'h202);
        vecs[25] = mk(1, 2'b01, 32'h300,    32'h0,      1, 1, 1,   0, 32'h202,    0, 32'h0,   1, 32'h202);
        vecs[26] = mk(0, 2'b00, 32'h0,      32'h0,      1, 1, 1,   1, 32'h300,    0, 32'h0,   0, 32'h202);
        vecs[27] = mk(0, 2'b01, 32'h500,    32'h0,      1, 1, 1,   0, 32'h300,    0, 32'h0,   0, 32'h202);
        vecs[28] = mk(1, 2'b11, 32'h600,    32'h0,      1, 1, 1,   1, 32'h304,    1, 32'h300, 0, 32'h202);

        @(negedge clk);
        chk_reset("rst0");
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].exv, vecs[i].sel, vecs[i].tgt, vecs[i].jalr);
            id_ready       = vecs[i].rdy;
            imem_req_ready = vecs[i].rrdy;
            mem_lat        = vecs[i].lat;
            @(negedge clk);
            chk($sformatf("v%0d.req_valid", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d.req_addr", i),  imem_req_addr, vecs[i].e_addr);
            chk($sformatf("v%0d.id_valid", i),  {31'd0, id_valid}, {31'd0, vecs[i].e_idv});
            chk($sformatf("v%0d.fault", i),     {31'd0, fetch_fault}, {31'd0, vecs[i].e_flt});
            chk($sformatf("v%0d.fault_pc", i),  fault_pc, vecs[i].e_fpc);
            if (vecs[i].e_idv) begin
                chk($sformatf("v%0d.id_pc", i),    id_pc, vecs[i].e_idpc);
                chk($sformatf("v%0d.id_instr", i), id_instr, ~vecs[i].e_idpc);
                chk($sformatf("v%0d.id_pc4", i),   id_pc_plus4, vecs[i].e_idpc + 32'd4);
            end
            tick();
        end

        // Misaligned jalr while a 3-cycle fetch of 0x308 is outstanding, then
        // aligned redirect before that beat lands: must drain, not load it.
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        id_ready = 1'b1;
        imem_req_ready = 1'b1;
        mem_lat = 3;
        tick();
        #2;
        chk("owed.req_0x308", {31'd0, imem_req_valid}, 32'd1);
        chk("owed.addr_0x308", imem_req_addr, 32'h308);
        tick();
        drive(1'b1, 2'b10, 32'h0, 32'h406);
        #2;
        chk("owed.no_req_redirect", {31'd0, imem_req_valid}, 32'd0);
        tick();
        drive(1'b1, 2'b01, 32'h400, 32'h0);
        #2;
        chk("owed.fault", {31'd0, fetch_fault}, 32'd1);
        chk("owed.fault_pc", fault_pc, 32'h406);
        chk("owed.fault_no_req", {31'd0, imem_req_valid}, 32'd0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        mem_lat = 1;
        #2;
        chk("owed.fault_clear", {31'd0, fetch_fault}, 32'd0);
        chk("owed.drain_no_req", {31'd0, imem_req_valid}, 32'd0);
        chk("owed.drain_rsp_seen", {31'd0, imem_rsp_valid}, 32'd1);
        tick();
        #2;
        chk("owed.req_0x400", {31'd0, imem_req_valid}, 32'd1);
        chk("owed.addr_0x400", imem_req_addr, 32'h400);
        chk("owed.discarded", {31'd0, id_valid}, 32'd0);
        tick();
        tick();

        // Fetch of 0x400 landed; redirect to the last word to check wrap.
        drive(1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0);
        #2;
        chk("wrap.id_pc_0x400", id_pc, 32'h400);
        chk("wrap.id_instr_0x400", id_instr, ~32'h400);
        chk("wrap.no_req_redirect", {31'd0, imem_req_valid}, 32'd0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        #2;
        chk("wrap.addr_top", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        mem_lat = 3;
        #2;
        chk("wrap.id_pc_top", id_pc, 32'hFFFF_FFFC);
        chk("wrap.id_pc4_zero", id_pc_plus4, 32'h0);
        chk("wrap.req_zero", {31'd0, imem_req_valid}, 32'd1);
        chk("wrap.addr_zero", imem_req_addr, 32'h0);
        tick();

        // Asynchronous reset while the fetch of 0x0 is in flight.
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        tick();
        rst_n = 1'b1;
        mem_lat = 1;
        #2;
        chk("rst_mid.req_restart", {31'd0, imem_req_valid}, 32'd1);
        chk("rst_mid.addr_restart", imem_req_addr, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
